// File: rtl/inertial_pkg.sv
// Shared types and command words for the IMU front end and its SPI master.
// No logic of its own; no latency, no backpressure.
package inertial_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AZL,
        RD_AZH,
        VALID
    } state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_XFER,
        SPI_DONE
    } spi_state_t;

    localparam logic [15:0] CFG_INT_DRDY = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL    = 16'h1053;
    localparam logic [15:0] CFG_GYRO     = 16'h1150;
    localparam logic [15:0] CFG_ROUND    = 16'h1460;

    localparam logic [15:0] RD_PL_CMD  = 16'hA200;
    localparam logic [15:0] RD_PH_CMD  = 16'hA300;
    localparam logic [15:0] RD_AZL_CMD = 16'hAC00;
    localparam logic [15:0] RD_AZH_CMD = 16'hAD00;

    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = CFG_INT_DRDY;
            2'd1:    w = CFG_ACCEL;
            2'd2:    w = CFG_GYRO;
            default: w = CFG_ROUND;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI master (mode 3); one transfer is 16.5 SCLK periods plus 2 clks to done.
// Busy while a transfer runs: wrt is ignored until done has pulsed.
module spi_mnrch
    import inertial_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [7:0]  rsp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);
    localparam logic [5:0]    LAST_EDGE = 6'd32;

    spi_state_t     st_q, st_d;
    logic [DW-1:0]  div_q, div_d;
    logic [5:0]     edge_q, edge_d;
    logic [15:0]    shft_q, shft_d;
    logic           ss_n_q, ss_n_d;
    logic           sclk_q, sclk_d;
    logic           mosi_q, mosi_d;
    logic           done_q, done_d;
    logic           half_end;

    // Half-period events alternate fall (even) / rise (odd); event 32 closes the frame
    // half a period after the 16th rise, so SCLK never makes a 17th fall.
    always_comb begin
        st_d     = st_q;
        div_d    = div_q;
        edge_d   = edge_q;
        shft_d   = shft_q;
        ss_n_d   = ss_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        half_end = (div_q == HALF_LAST);
        case (st_q)
            SPI_IDLE: begin
                if (wrt) begin
                    st_d   = SPI_XFER;
                    ss_n_d = 1'b0;
                    shft_d = cmd;
                    div_d  = '0;
                    edge_d = '0;
                end
            end
            SPI_XFER: begin
                div_d = half_end ? '0 : div_q + 1'b1;
                if (half_end) begin
                    edge_d = edge_q + 6'd1;
                    if (edge_q == LAST_EDGE) begin
                        ss_n_d = 1'b1;
                        st_d   = SPI_DONE;
                    end else if (!edge_q[0]) begin
                        sclk_d = 1'b0;
                        mosi_d = shft_q[15];
                    end else begin
                        sclk_d = 1'b1;
                        shft_d = {shft_q[14:0], MISO};
                    end
                end
            end
            SPI_DONE: begin
                done_d = 1'b1;
                st_d   = SPI_IDLE;
            end
            default: st_d = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= SPI_IDLE;
            div_q  <= '0;
            edge_q <= '0;
            shft_q <= '0;
            ss_n_q <= 1'b1;
            sclk_q <= 1'b1;
            mosi_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            div_q  <= div_d;
            edge_q <= edge_d;
            shft_q <= shft_d;
            ss_n_q <= ss_n_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign rsp  = shft_q[7:0];
    assign SS_n = ss_n_q;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;

endmodule

// File: rtl/inertial_intf.sv
// IMU front end: settle, configure, then on each data-ready read pitch rate and AZ.
// Latency INT->vld is 4 SPI transfers plus sync/FSM overhead; no backpressure, vld is a pulse.
module inertial_intf
    import inertial_pkg::*;
#(
    parameter int INIT_W   = 16,
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  tmr_q, tmr_d;
    logic [1:0]         cfg_idx_q, cfg_idx_d;
    logic               int_ff1_q, int_ff1_d;
    logic               int_ff2_q, int_ff2_d;
    logic [7:0]         pl_q, pl_d;
    logic [7:0]         ph_q, ph_d;
    logic [7:0]         azl_q, azl_d;
    logic [15:0]        ptch_q, ptch_d;
    logic [15:0]        az_q, az_d;
    logic               vld_q, vld_d;

    logic               wrt;
    logic [15:0]        cmd;
    logic               done;
    logic [7:0]         rsp;

    spi_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt),
        .cmd  (cmd),
        .done (done),
        .rsp  (rsp),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    // Each transfer is launched on the same clk the previous done is seen, so the
    // SPI master is always back in its idle state when wrt arrives.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cfg_idx_d = cfg_idx_q;
        int_ff1_d = INT;
        int_ff2_d = int_ff1_q;
        pl_d      = pl_q;
        ph_d      = ph_q;
        azl_d     = azl_q;
        ptch_d    = ptch_q;
        az_d      = az_q;
        vld_d     = 1'b0;
        wrt       = 1'b0;
        cmd       = RD_PL_CMD;
        case (state_q)
            INIT_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (&tmr_q) begin
                    state_d   = CFG;
                    cfg_idx_d = 2'd0;
                    wrt       = 1'b1;
                    cmd       = cfg_word(2'd0);
                end
            end
            CFG: begin
                if (done) begin
                    if (cfg_idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                        wrt       = 1'b1;
                        cmd       = cfg_word(cfg_idx_q + 2'd1);
                    end
                end
            end
            IDLE: begin
                if (int_ff2_q) begin
                    state_d = RD_PL;
                    wrt     = 1'b1;
                    cmd     = RD_PL_CMD;
                end
            end
            RD_PL: begin
                if (done) begin
                    pl_d    = rsp;
                    state_d = RD_PH;
                    wrt     = 1'b1;
                    cmd     = RD_PH_CMD;
                end
            end
            RD_PH: begin
                if (done) begin
                    ph_d    = rsp;
                    state_d = RD_AZL;
                    wrt     = 1'b1;
                    cmd     = RD_AZL_CMD;
                end
            end
            RD_AZL: begin
                if (done) begin
                    azl_d   = rsp;
                    state_d = RD_AZH;
                    wrt     = 1'b1;
                    cmd     = RD_AZH_CMD;
                end
            end
            RD_AZH: begin
                // Both words load together so VALID shows a complete sample with vld.
                if (done) begin
                    ptch_d  = {ph_q, pl_q};
                    az_d    = {rsp, azl_q};
                    vld_d   = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: state_d = IDLE;
            default: state_d = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT_WAIT;
            tmr_q     <= '0;
            cfg_idx_q <= 2'd0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            pl_q      <= 8'h00;
            ph_q      <= 8'h00;
            azl_q     <= 8'h00;
            ptch_q    <= 16'h0000;
            az_q      <= 16'h0000;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cfg_idx_q <= cfg_idx_d;
            int_ff1_q <= int_ff1_d;
            int_ff2_q <= int_ff2_d;
            pl_q      <= pl_d;
            ph_q      <= ph_d;
            azl_q     <= azl_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            vld_q     <= vld_d;
        end
    end

    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_intf.sv
// Directed bench for inertial_intf with a behavioural IMU SPI slave.
module tb_inertial_intf;

    localparam int INIT_W      = 6;
    localparam int SCLK_DIV    = 32;
    localparam int LAT_MAX     = 4 * (17 * SCLK_DIV + 4) + 4 + 3;
    localparam int READ_PERIOD = 2122;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    always #5 clk = ~clk;

    inertial_intf #(.INIT_W(INIT_W), .SCLK_DIV(SCLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          vld_cnt   = 0;
    int          cyc       = 0;
    int          frame_err = 0;
    int          nbit      = 0;
    logic [15:0] rx;
    logic [7:0]  addr;
    logic [7:0]  mbyte;
    logic [7:0]  regs [0:255];
    logic [15:0] cap_q [$];
    logic [15:0] cfg_exp [4];
    logic [15:0] rd_exp [4];
    logic [15:0] exp_hold_p, exp_hold_a;
    bit          hold_bad;

    always @(posedge clk) begin
        cyc++;
        if (vld === 1'b1) vld_cnt++;
    end

    // IMU slave: high byte selects the register, data returned in the low byte.
    always @(negedge SS_n) begin
        nbit = 0;
        rx   = '0;
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            rx = {rx[14:0], MOSI};
            nbit++;
            if (nbit == 8) addr = rx[7:0];
        end
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && nbit >= 8 && nbit < 16) begin
            mbyte = regs[addr];
            MISO  = mbyte[15 - nbit];
        end
    end

    always @(posedge SS_n) begin
        if (rst === 1'b0) begin
            if (nbit != 16) frame_err++;
            cap_q.push_back(rx);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input int max, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max) begin
            @(negedge clk);
            lat++;
            if (vld === 1'b1) seen = 1'b1;
            else if (ptch_rt !== exp_hold_p || AZ !== exp_hold_a) hold_bad = 1'b1;
        end
    endtask

    task automatic wait_caps(input int n, input int max, output bit ok);
        int k;
        k  = 0;
        ok = 1'b0;
        while (k < max && !ok) begin
            @(negedge clk);
            k++;
            if (cap_q.size() >= n) ok = 1'b1;
        end
    endtask

    function automatic logic [15:0] cap_at(input int i);
        return (i < cap_q.size()) ? cap_q[i] : 16'hxxxx;
    endfunction

    task automatic pulse_int();
        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
    endtask

    initial begin
        int lat, k, t1, t2, t3, v0;
        bit ok, ok2, ok3;
        rst = 1'b1;
        INT = 1'b0;
        MISO = 1'b0;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        cfg_exp[0] = 16'h0D02; cfg_exp[1] = 16'h1053;
        cfg_exp[2] = 16'h1150; cfg_exp[3] = 16'h1460;
        rd_exp[0]  = 16'hA200; rd_exp[1]  = 16'hA300;
        rd_exp[2]  = 16'hAC00; rd_exp[3]  = 16'hAD00;
        exp_hold_p = 16'h0000;
        exp_hold_a = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_vld",   vld, 0);
        check("rst_ptch",  ptch_rt, 0);
        check("rst_az",    AZ, 0);
        check("rst_ss_n",  SS_n, 1);
        check("rst_sclk",  SCLK, 1);
        check("rst_mosi",  MOSI, 0);

        // Power-up settle then configuration
        rst = 1'b0;
        k = 0;
        while (k < 200 && SS_n !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        check("init_ss_fall_seen", SS_n, 0);
        check("init_wait_ge_64", (k >= 64), 1);
        wait_caps(4, 4000, ok);
        check("cfg_done", ok, 1);
        repeat (50) @(negedge clk);
        check("cfg_count", cap_q.size(), 4);
        for (int i = 0; i < 4; i++) check("cfg_word", cap_at(i), cfg_exp[i]);
        check("cfg_frame_err", frame_err, 0);
        check("cfg_no_vld", vld_cnt, 0);

        // First read
        regs[8'hA2] = 8'h34; regs[8'hA3] = 8'h12;
        regs[8'hAC] = 8'hCD; regs[8'hAD] = 8'hAB;
        cap_q.delete();
        pulse_int();
        wait_vld(LAT_MAX, lat, ok);
        check("rd1_vld_seen", ok, 1);
        check("rd1_ptch", ptch_rt, 16'h1234);
        check("rd1_az", AZ, 16'hABCD);
        check("rd1_latency", (lat + 2 <= LAT_MAX), 1);
        @(negedge clk);
        check("rd1_vld_one_clk", vld, 0);
        for (int i = 0; i < 4; i++) check("rd1_cmd", cap_at(i), rd_exp[i]);
        check("rd1_frame_err", frame_err, 0);

        // Signed extremes; previous sample must hold until the new vld
        regs[8'hA2] = 8'h80; regs[8'hA3] = 8'hFF;
        regs[8'hAC] = 8'h01; regs[8'hAD] = 8'h80;
        exp_hold_p = 16'h1234;
        exp_hold_a = 16'hABCD;
        hold_bad = 1'b0;
        v0 = vld_cnt;
        pulse_int();
        wait_vld(LAT_MAX, lat, ok);
        check("rd2_vld_seen", ok, 1);
        check("rd2_ptch", ptch_rt, 16'hFF80);
        check("rd2_az", AZ, 16'h8001);
        check("rd2_hold", hold_bad, 0);
        check("rd2_latency", (lat + 2 <= LAT_MAX), 1);
        repeat (3000) @(negedge clk);
        check("rd2_single_read", vld_cnt, v0 + 1);

        // Short INT glitch during RD_PH is not queued
        regs[8'hA2] = 8'h34; regs[8'hA3] = 8'h12;
        regs[8'hAC] = 8'hCD; regs[8'hAD] = 8'hAB;
        exp_hold_p = 16'hFF80;
        exp_hold_a = 16'h8001;
        cap_q.delete();
        v0 = vld_cnt;
        pulse_int();
        wait_caps(1, 1000, ok);
        k = 0;
        while (k < 50 && SS_n !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        repeat (100) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_vld(LAT_MAX, lat, ok2);
        check("glitch_rd_seen", (ok && ok2), 1);
        check("glitch_ptch", ptch_rt, 16'h1234);
        repeat (3000) @(negedge clk);
        check("glitch_no_extra_vld", vld_cnt, v0 + 1);
        check("glitch_no_extra_xfer", cap_q.size(), 4);

        // INT held high: back-to-back reads at a fixed period
        exp_hold_p = 16'h1234;
        exp_hold_a = 16'hABCD;
        INT = 1'b1;
        wait_vld(LAT_MAX, lat, ok);
        t1 = cyc;
        @(negedge clk);
        check("held_vld_one_clk", vld, 0);
        wait_vld(LAT_MAX, lat, ok2);
        t2 = cyc;
        @(negedge clk);
        wait_vld(LAT_MAX, lat, ok3);
        t3 = cyc;
        check("held_all_seen", (ok && ok2 && ok3), 1);
        check("held_period1", t2 - t1, READ_PERIOD);
        check("held_period2", t3 - t2, READ_PERIOD);
        INT = 1'b0;
        @(negedge clk);
        wait_vld(LAT_MAX, lat, ok);
        repeat (10) @(negedge clk);

        // Reset in the middle of RD_AZL
        cap_q.delete();
        pulse_int();
        wait_caps(2, 2000, ok);
        k = 0;
        while (k < 50 && SS_n !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        repeat (100) @(negedge clk);
        k = 0;
        while (k < 40 && SCLK !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        check("mid_azl_active", (ok && SS_n === 1'b0 && SCLK === 1'b0), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_ss_n", SS_n, 1);
        check("arst_sclk", SCLK, 1);
        check("arst_vld", vld, 0);
        check("arst_ptch", ptch_rt, 0);
        check("arst_az", AZ, 0);
        repeat (3) @(negedge clk);
        cap_q.delete();
        v0 = vld_cnt;
        rst = 1'b0;
        wait_caps(4, 4000, ok);
        check("recfg_done", ok, 1);
        for (int i = 0; i < 4; i++) check("recfg_word", cap_at(i), cfg_exp[i]);
        check("recfg_ptch_zero", ptch_rt, 0);
        check("recfg_az_zero", AZ, 0);
        check("recfg_no_vld", vld_cnt, v0);

        exp_hold_p = 16'h0000;
        exp_hold_a = 16'h0000;
        hold_bad = 1'b0;
        repeat (20) @(negedge clk);
        pulse_int();
        wait_vld(LAT_MAX, lat, ok);
        check("post_rst_vld_seen", ok, 1);
        check("post_rst_ptch", ptch_rt, 16'h1234);
        check("post_rst_az", AZ, 16'hABCD);
        check("post_rst_hold_zero", hold_bad, 0);
        check("final_frame_err", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
